// File: rtl/sa_out_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sa_out_arbiter
//   Switch-allocation arbiter for one output direction of a 2-D mesh router.
//   The four input channels (L, W, E, N) compete for a single output link.
//   Arbitration is round-robin at packet granularity. A head flit takes a
//   wormhole lock that is held until the matching tail flit. If the lock owner
//   stalls for TIMEOUT cycles, the lock is forcibly released. Downstream
//   backpressure (out_full) blocks every transfer.
//
//   Optional build macro: SA_ARB_STATS_EN adds the flit_cnt and grant_cnt
//   statistics ports.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid[3:0] per-input request (0=L, 1=W, 2=E, 3=N)
//   req_data      packed flits, slice i = [i*DATASIZE +: DATASIZE]
//   req_ready[3:0] one-hot combinational pop strobe to the granted input
//   out_full      downstream buffer full
//   out_valid     registered one-cycle flit valid
//   out_data      registered flit; holds its last value between flits
//   lock_owner    owning input while locked
//   locked        wormhole lock held
//   lock_timeout  one-cycle pulse on forced lock release
//   flit_cnt      (SA_ARB_STATS_EN) wrapping count of accepted flits
//   grant_cnt     (SA_ARB_STATS_EN) per-input saturating count of IDLE grants,
//                 byte i = input i
// ---------------------------------------------------------------------------
module sa_out_arbiter #(
    parameter int DATASIZE = 40,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              req_valid,
    input  logic [4*DATASIZE-1:0]   req_data,
    output logic [3:0]              req_ready,
    input  logic                    out_full,
    output logic                    out_valid,
    output logic [DATASIZE-1:0]     out_data,
    output logic [1:0]              lock_owner,
    output logic                    locked,
    output logic                    lock_timeout
`ifdef SA_ARB_STATS_EN
    ,
    output logic [15:0]             flit_cnt,
    output logic [31:0]             grant_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b11;

    state_t                state;
    logic [1:0]            rr_ptr;
    logic [1:0]            owner;
    logic [TO_W-1:0]       idle_cnt;

    logic                  vld_p1;
    logic [DATASIZE-1:0]   data_p1;
    logic                  timeout_p1;

    logic [2:0]            pick;
    logic                  sel_hit;
    logic [1:0]            sel_idx;
    logic                  accept;
    logic [DATASIZE-1:0]   sel_flit;
    logic [1:0]            sel_type;
    logic                  owner_stall;

    // Returns {hit, index}: the first requester found when scanning from ptr
    // upward, modulo 4. The descending loop lets the nearest candidate
    // overwrite the farther ones.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // ---- stage p0: selection and combinational grant ----
    always_comb begin
        pick = rr_pick(req_valid, rr_ptr);
        if (state == LOCKED) begin
            sel_hit = req_valid[owner];
            sel_idx = owner;
        end else begin
            sel_hit = pick[2];
            sel_idx = pick[1:0];
        end
    end

    // rst_n gates the strobe so that no source pops while the arbiter is held in reset.
    assign accept    = sel_hit & ~out_full & rst_n;
    assign req_ready = accept ? (4'b0001 << sel_idx) : 4'b0000;
    assign sel_flit  = req_data[sel_idx*DATASIZE +: DATASIZE];
    assign sel_type  = sel_flit[1:0];

    // A stall counts toward the timeout only when the owner has nothing to
    // send. A cycle blocked by out_full freezes the counter.
    assign owner_stall = (state == LOCKED) & ~out_full & ~req_valid[owner];

    // ---- stage p1: registered state and output flit ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 2'd0;
            owner      <= 2'd0;
            idle_cnt   <= '0;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            timeout_p1 <= 1'b0;
        end else begin
            vld_p1     <= accept;
            timeout_p1 <= 1'b0;
            if (accept) begin
                data_p1  <= sel_flit;
                idle_cnt <= '0;
                if (state == IDLE) begin
                    rr_ptr <= sel_idx + 2'd1;
                    if (sel_type == T_HEAD) begin
                        state <= LOCKED;
                        owner <= sel_idx;
                    end
                end else if (sel_type == T_TAIL || sel_type == T_SINGLE) begin
                    // rr_ptr already moved past the owner when the head flit was granted.
                    state <= IDLE;
                end
            end else if (owner_stall) begin
                // Release on the increment that would reach TIMEOUT, so the
                // counter itself never holds the value TIMEOUT.
                if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                    state      <= IDLE;
                    idle_cnt   <= '0;
                    timeout_p1 <= 1'b1;
                    rr_ptr     <= owner + 2'd1;
                end else begin
                    idle_cnt <= idle_cnt + TO_W'(1);
                end
            end
        end
    end

    assign out_valid    = vld_p1;
    assign out_data     = data_p1;
    assign lock_timeout = timeout_p1;
    assign lock_owner   = owner;
    assign locked       = (state == LOCKED);

`ifdef SA_ARB_STATS_EN
    logic [7:0] gcnt [4];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---- stage p1: statistics ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt <= 16'd0;
            for (int i = 0; i < 4; i++) gcnt[i] <= 8'd0;
        end else if (accept) begin
            flit_cnt <= flit_cnt + 16'd1;
            if (state == IDLE) gcnt[sel_idx] <= sat_inc8(gcnt[sel_idx]);
        end
    end

    assign grant_cnt = {gcnt[3], gcnt[2], gcnt[1], gcnt[0]};
`endif

endmodule

// File: tb/tb_sa_out_arbiter.sv
`timescale 1ns/1ps
// Bench for sa_out_arbiter. It checks the arbiter with a scoreboard against a
// behavioural model of the packet-level arbitration rules.
module tb_sa_out_arbiter;

    localparam int DS = 40;
    localparam int TO = 16;
    localparam int TW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req_valid = 4'b0;
    logic [4*DS-1:0]   req_data = '0;
    logic [3:0]        req_ready;
    logic              out_full = 1'b0;
    logic              out_valid;
    logic [DS-1:0]     out_data;
    logic [1:0]        lock_owner;
    logic              locked;
    logic              lock_timeout;
`ifdef SA_ARB_STATS_EN
    logic [15:0]       flit_cnt;
    logic [31:0]       grant_cnt;
`endif

    sa_out_arbiter #(.DATASIZE(DS), .TIMEOUT(TO), .TO_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_full     (out_full),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .lock_owner   (lock_owner),
        .locked       (locked),
        .lock_timeout (lock_timeout)
`ifdef SA_ARB_STATS_EN
        ,
        .flit_cnt     (flit_cnt),
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus sources, scoreboard and grant log
    logic [DS-1:0] srcq [4][$];
    logic [DS-1:0] expq [$];
    int            glog [$];
    int            exp_g [$];
    logic [3:0]    en = 4'b0;
    logic          full_cmd = 1'b0;
    int            acc_idx = -1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_locked = 0;
    bit m_to = 0;
    int m_owner = 0;
    int m_rr = 0;
    int m_idle = 0;
    int m_flits = 0;
    int m_gcnt [4];
    int cyc = 0;
    int head_cyc = 0;
    int to_cyc = 0;
    int to_seen = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DS-1:0] mk(int s, int typ);
        return {4'(s), 4'($urandom_range(0, 15)), 8'($urandom), 22'($urandom), 2'(typ)};
    endfunction

    function automatic void drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = en[i] && (srcq[i].size() > 0);
            req_data[i*DS +: DS] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
        end
        out_full = full_cmd;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_idx >= 0 && srcq[acc_idx].size() > 0) void'(srcq[acc_idx].pop_front());
        drive();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) srcq[i].delete();
    endtask

    task automatic drain();
        en = 4'b0;
        full_cmd = 1'b0;
        repeat (4) step();
        clear_src();
    endtask

    task automatic chk_glog(string nm, input int e[$]);
        chk({nm, "_count"}, 64'(glog.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < glog.size()) chk(nm, 64'(glog[i]), 64'(e[i]));
            else chk(nm, 64'hFFFF, 64'(e[i]));
        end
    endtask

    task automatic add_pkt(int s);
        int r;
        r = $urandom_range(0, 99);
        if (r < 25) srcq[s].push_back(mk(s, 0));
        else if (r < 35) srcq[s].push_back(mk(s, $urandom_range(2, 3)));
        else begin
            srcq[s].push_back(mk(s, 1));
            repeat ($urandom_range(0, 3)) srcq[s].push_back(mk(s, 2));
            srcq[s].push_back(mk(s, 3));
        end
    endtask

    // Reference model: packet-level arbitration rules, evaluated once per cycle
    always @(negedge clk) begin : model
        int g;
        logic [3:0] exp_rdy;
        logic [DS-1:0] f;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_idle = 0; m_to = 0;
            m_flits = 0;
            for (int i = 0; i < 4; i++) m_gcnt[i] = 0;
            acc_idx = -1;
            expq.delete();
        end else begin
            cyc++;
            chk("locked", 64'(locked), 64'(m_locked));
            if (m_locked) chk("lock_owner", 64'(lock_owner), 64'(m_owner));
            chk("lock_timeout", 64'(lock_timeout), 64'(m_to));
            if (lock_timeout === 1'b1) begin
                to_seen++;
                to_cyc = cyc;
            end
            m_to = 0;

            g = -1;
            if (m_locked) begin
                if (req_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 3; k >= 0; k--)
                    if (req_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            end
            exp_rdy = (g >= 0 && !out_full) ? 4'(1 << g) : 4'b0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));

            acc_idx = -1;
            if (g >= 0 && !out_full) begin
                f = srcq[g][0];
                expq.push_back(f);
                glog.push_back(g);
                acc_idx = g;
                m_idle = 0;
                m_flits++;
                if (!m_locked) begin
                    m_rr = (g + 1) % 4;
                    if (m_gcnt[g] < 255) m_gcnt[g]++;
                    if (f[1:0] == 2'b01) begin
                        m_locked = 1;
                        m_owner = g;
                        head_cyc = cyc;
                    end
                end else if (f[1:0] == 2'b11 || f[1:0] == 2'b00) begin
                    m_locked = 0;
                end
            end else if (m_locked && !out_full) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_locked = 0;
                    m_idle = 0;
                    m_to = 1;
                    m_rr = (m_owner + 1) % 4;
                end
            end
        end
    end

    // Monitor: every out_valid pulse must deliver the oldest expected flit
    always @(negedge clk) begin : monitor
        logic [DS-1:0] e;
        if (rst_n && out_valid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("out_unexpected", 64'(out_data), 64'hDEAD);
            end else begin
                e = expq.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int off [4];
        int pushed;
        int to_before;

        // Reset values; req_ready must stay low while reset is held, even with requests pending
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        req_data = {4{40'hA5A5A5A5A5}};
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_lock_owner", 64'(lock_owner), 64'h0);
        chk("rst_lock_timeout", 64'(lock_timeout), 64'h0);
        en = 4'b0;
        drive();
        step();
        rst_n = 1'b1;

        // Round robin over single flits
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            srcq[i].push_back(mk(i, 0));
            srcq[i].push_back(mk(i, 0));
        end
        en = 4'b1111;
        repeat (4) step();
        settle();
        exp_g = '{0, 1, 2, 3};
        chk_glog("rr_order", exp_g);
        repeat (4) step();
        drain();

        // Wormhole lock: W packet while L and E keep requesting
        glog.delete();
        srcq[1].push_back(mk(1, 1));
        srcq[1].push_back(mk(1, 2));
        srcq[1].push_back(mk(1, 3));
        for (int i = 0; i < 4; i++) begin
            srcq[0].push_back(mk(0, 0));
            srcq[2].push_back(mk(2, 0));
        end
        en = 4'b0010;
        step();
        en = 4'b0111;
        repeat (4) step();
        settle();
        exp_g = '{1, 1, 1, 2, 0};
        chk_glog("wormhole", exp_g);
        drain();

        // Backpressure in the middle of a packet
        glog.delete();
        to_before = to_seen;
        srcq[1].push_back(mk(1, 1));
        srcq[1].push_back(mk(1, 2));
        srcq[1].push_back(mk(1, 2));
        srcq[1].push_back(mk(1, 3));
        en = 4'b0010;
        step();
        step();
        full_cmd = 1'b1;
        repeat (3) step();
        full_cmd = 1'b0;
        repeat (3) step();
        settle();
        exp_g = '{1, 1, 1, 1};
        chk_glog("backpressure", exp_g);
        chk("bp_no_timeout", 64'(to_seen), 64'(to_before));
        drain();

        // Lock timeout: N sends only a head flit, then goes silent
        glog.delete();
        to_before = to_seen;
        srcq[3].push_back(mk(3, 1));
        en = 4'b1000;
        step();
        repeat (20) step();
        srcq[0].push_back(mk(0, 0));
        srcq[1].push_back(mk(1, 0));
        en = 4'b0011;
        step();
        step();
        settle();
        chk("timeout_pulses", 64'(to_seen - to_before), 64'd1);
        // The head is sampled in cycle c and registered at edge c. The pulse
        // follows edge c+16, so it is observed at sample c+17.
        chk("timeout_delay", 64'(to_cyc - head_cyc), 64'd17);
        exp_g = '{3, 0, 1};
        chk_glog("after_timeout", exp_g);
        drain();

        // Asynchronous reset in the middle of a packet
        srcq[2].push_back(mk(2, 1));
        srcq[2].push_back(mk(2, 2));
        srcq[2].push_back(mk(2, 2));
        srcq[2].push_back(mk(2, 3));
        en = 4'b0100;
        step();
        step();
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_out_data", 64'(out_data), 64'h0);
        chk("mid_rst_locked", 64'(locked), 64'h0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
        clear_src();
        en = 4'b0;
        repeat (2) step();
        rst_n = 1'b1;
        glog.delete();
        srcq[1].push_back(mk(1, 0));
        srcq[3].push_back(mk(3, 0));
        en = 4'b1010;
        step();
        step();
        settle();
        exp_g = '{1, 3};
        chk_glog("after_reset", exp_g);
        drain();

        // Randomized traffic with stray flits, silent sources and backpressure
        for (int i = 0; i < 4; i++) off[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) add_pkt(i);
                if (off[i] > 0) off[i]--;
                else if ($urandom_range(0, 99) < 3) off[i] = $urandom_range(8, 24);
                en[i] = (off[i] == 0) && ($urandom_range(0, 4) != 0);
            end
            full_cmd = ($urandom_range(0, 4) == 0);
            step();
        end
        en = 4'b0;
        full_cmd = 1'b0;
        repeat (30) step();
        clear_src();
        settle();
        chk("random_drained", 64'(expq.size()), 64'd0);
        chk("random_timeouts_seen", 64'(to_seen > 1), 64'd1);

`ifdef SA_ARB_STATS_EN
        // Statistics: 70000 single flits from L after a fresh reset
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        pushed = 0;
        en = 4'b0001;
        while (pushed < 70000 || srcq[0].size() > 0) begin
            if (pushed < 70000 && srcq[0].size() < 2) begin
                srcq[0].push_back(mk(0, 0));
                pushed++;
            end
            step();
        end
        repeat (3) step();
        settle();
        chk("flit_cnt_model", 64'(flit_cnt), 64'(m_flits % 65536));
        chk("flit_cnt", 64'(flit_cnt), 64'd4464);
        chk("grant_cnt_L", 64'(grant_cnt[7:0]), 64'hFF);
        chk("grant_cnt_W", 64'(grant_cnt[15:8]), 64'(m_gcnt[1]));
`else
        pushed = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_out_arbiter.md
Name: sa_out_arbiter

Overview:
- Per-output-port switch-allocation arbiter for the 2-D mesh router.
- Shares one output link among the four input channels L, W, E and N after route computation (RC).
- Round-robin at packet granularity, with a wormhole lock held from head flit to tail flit.
- Honours the downstream full backpressure. One instance is built per output direction.

Parameters:
- DATASIZE, 40: flit width. Field map: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].
- TIMEOUT, 16: idle cycles the lock owner may stall before the lock is forcibly released.
- TO_W, 5: counter width. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 4: per-input request to this output. Bit 0=L, 1=W, 2=E, 3=N.
- req_data, input, 4*DATASIZE: packed flits. Slice i is [i*DATASIZE +: DATASIZE].
- req_ready, output, 4: one-hot pop strobe to the granted input, combinational.
- out_full, input, 1: downstream buffer full.
- out_valid, output, 1: registered flit-valid pulse.
- out_data, output, DATASIZE: registered flit.
- lock_owner, output, 2: current owner index; meaningful only while locked=1.
- locked, output, 1: 1 while in state LOCKED.
- lock_timeout, output, 1: one-cycle pulse when the lock is force-released.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, out_valid=0, out_data=0, lock_owner=0, locked=0, lock_timeout=0, idle counter=0. req_ready is 0 while rst_n=0.
- Type codes: 00=single, 01=head, 10=body, 11=tail.
- Accept condition: a flit is accepted in cycle t iff req_ready[g]=1.
  - req_ready[g] = selected(g) & req_valid[g] & ~out_full.
  - At most one req_ready bit is set per cycle.
- Latency: out_data and out_valid update at edge t+1. out_valid=1 for exactly one cycle per accepted flit, otherwise 0. out_data holds its last value when no flit is accepted.
- IDLE state:
  - selected = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod 4.
  - On accept with type 01: go to LOCKED, lock_owner=g.
  - On accept with type 00, 10 or 11: stay in IDLE. Types 10/11 arriving in IDLE are forwarded as single flits.
  - On any accept: rr_ptr <= (g+1) mod 4.
- LOCKED state:
  - selected = lock_owner only; all other inputs are held off.
  - On accept with type 11 or 00: go to IDLE. rr_ptr is unchanged; it was already advanced at the head flit.
  - On accept with type 01 or 10: stay LOCKED.
- Idle counter (LOCKED state only):
  - Increments on each cycle the owner does not get a flit accepted because req_valid[owner]=0.
  - Cycles blocked by out_full do not count and do not clear the counter.
  - Clears on every accept.
  - When the counter reaches TIMEOUT: force IDLE, pulse lock_timeout, clear the counter, rr_ptr=(owner+1) mod 4.
- out_full=1: no accept, no state change, no rr_ptr change. out_valid=0 next cycle.
- Simultaneous timeout and accept in the same cycle: the accept wins and the counter clears.
- Asynchronous reset mid-packet drops the lock immediately. The partially forwarded packet is not recovered.

Optional Feature:
- Macro: SA_ARB_STATS_EN.
- When defined, adds output flit_cnt (16 bits): count of accepted flits, reset 0, wraps 0xFFFF->0x0000.
- Also adds output grant_cnt (4x8 bits packed): per-input count of packets granted from IDLE, saturating at 0xFF.
- When undefined, neither port exists and the logic is removed.

Test Plan:
- Round-robin: req_valid=4'b1111, all inputs single flits (type 00), out_full=0, 4 cycles -> grants go L,W,E,N (req_ready 0001, 0010, 0100, 1000). out_valid is high for 4 cycles starting the cycle after the first grant.
- Wormhole lock: W sends head, body, tail while L and E request continuously -> req_ready[1] for 3 consecutive cycles; locked=1 for the head and body cycles; the next grant goes to E (rr_ptr=2).
- Backpressure: out_full=1 for 3 cycles mid-packet -> req_ready=0 and out_valid=0 in those cycles. The packet resumes with no flit lost or duplicated, and lock_timeout stays 0.
- Timeout: N sends a head then drops req_valid with TIMEOUT=16 -> lock_timeout pulses 16 cycles after the head accept. Next grant goes to L; rr_ptr=0.
- Reset: assert rst_n=0 mid-packet -> all outputs go to 0 asynchronously. After release, the first grant follows rr_ptr=0.
- Stats (SA_ARB_STATS_EN): 70000 accepted single flits from L -> flit_cnt=70000 mod 65536=4464, grant_cnt[L]=0xFF.
